// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder
//
// Captures request events from D into a pending register and issues them one
// at a time, highest priority first, as an encoded index on a registered
// valid/ready output.
//
// Parameters:
//   N          number of request lines (>= 2)
//   LSB_FIRST  0: highest index wins, 1: lowest index wins
//   EDGE       1: capture rising edges of D, 0: capture D levels every cycle
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous reset, active-high
//   D        in   N request lines
//   mask     in   N, 1 = bit is held pending but not issued
//   y        out  W encoded index of the issued request
//   valid    out  y holds an unaccepted index
//   ready    in   consumer accepts y when valid && ready at a clock edge
//   pending  out  N captured, not-yet-issued requests
//   overrun  out  sticky: an event hit a bit that was already pending
module pending_priority_encoder #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit EDGE      = 1'b1,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] D,
  input  logic [N-1:0] mask,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overrun
);

  logic [N-1:0] d_q;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;

  logic [N-1:0] rise;
  logic [N-1:0] elig;
  logic [N-1:0] issue_vec;
  logic [W-1:0] sel;
  logic         any;
  logic         load;

  // Event detection: with EDGE=0 a held level re-pends its bit every cycle.
  assign rise = EDGE ? (D & ~d_q) : D;
  assign elig = pending_q & ~mask;
  assign any  = |elig;

  // Priority select. The scan runs towards the winning end so the last hit
  // found is the one with priority.
  always_comb begin
    sel = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (elig[i]) sel = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) sel = W'(i);
      end
    end
  end

  // A new index loads when the slot is empty or is being accepted this edge,
  // which gives back-to-back issue with no bubble under continuous ready.
  assign load      = any && (!valid_q || ready);
  assign issue_vec = load ? (N'(1) << sel) : '0;

  always_comb begin
    y_d       = y_q;
    valid_d   = valid_q;
    if (load) begin
      y_d     = sel;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // Set wins over clear: a bit re-raised while issuing stays pending.
    pending_d = (pending_q & ~issue_vec) | rise;
    overrun_d = overrun_q | (|(rise & pending_q & ~issue_vec));
  end

  always_ff @(posedge clk) begin
    // D is sampled during reset too, so levels held through reset are not
    // seen as edges afterwards.
    d_q <= D;
    if (rst) begin
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed bench for pending_priority_encoder. Three instances share stimulus:
// default (MSB first, edge capture), LSB first, and level capture.
module tb_pending_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D;
  logic [7:0] mask;
  logic       ready;

  logic [2:0] y_a, y_b, y_c;
  logic       valid_a, valid_b, valid_c;
  logic [7:0] pend_a, pend_b, pend_c;
  logic       ovr_a, ovr_b, ovr_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(8), .LSB_FIRST(1'b0), .EDGE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .D(D), .mask(mask), .y(y_a), .valid(valid_a),
    .ready(ready), .pending(pend_a), .overrun(ovr_a)
  );

  pending_priority_encoder #(.N(8), .LSB_FIRST(1'b1), .EDGE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .D(D), .mask(mask), .y(y_b), .valid(valid_b),
    .ready(ready), .pending(pend_b), .overrun(ovr_b)
  );

  pending_priority_encoder #(.N(8), .LSB_FIRST(1'b0), .EDGE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .D(D), .mask(mask), .y(y_c), .valid(valid_c),
    .ready(ready), .pending(pend_c), .overrun(ovr_c)
  );

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; D = 8'h00; mask = 8'h00; ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset valid",   32'(valid_a), 32'd0);
    chk("reset y",       32'(y_a),     32'd0);
    chk("reset pending", 32'(pend_a),  32'h00);
    chk("reset overrun", 32'(ovr_a),   32'd0);

    // Single event
    D = 8'h20; step();
    chk("single pend k", 32'(pend_a), 32'h20);
    D = 8'h00; step();
    chk("single valid k1", 32'(valid_a), 32'd1);
    chk("single y k1",     32'(y_a),     32'd5);
    chk("single pend k1",  32'(pend_a),  32'h00);
    step();
    chk("single valid k2", 32'(valid_a), 32'd0);

    // Priority order, both directions
    D = 8'h81; step();
    chk("prio pend", 32'(pend_a), 32'h81);
    D = 8'h00; step();
    chk("prio msb y1",  32'(y_a), 32'd7);
    chk("prio lsb y1",  32'(y_b), 32'd0);
    chk("prio lsb v1",  32'(valid_b), 32'd1);
    step();
    chk("prio msb y2",  32'(y_a), 32'd0);
    chk("prio msb v2",  32'(valid_a), 32'd1);
    chk("prio lsb y2",  32'(y_b), 32'd7);
    step();
    chk("prio msb v3",  32'(valid_a), 32'd0);
    chk("prio lsb v3",  32'(valid_b), 32'd0);

    // Backpressure
    ready = 1'b0;
    D = 8'h04; step();
    D = 8'h00; step();
    chk("bp y2",     32'(y_a),     32'd2);
    chk("bp valid",  32'(valid_a), 32'd1);
    D = 8'h80; step();
    D = 8'h00; step();
    chk("bp hold y",    32'(y_a),    32'd2);
    chk("bp hold pend", 32'(pend_a), 32'h80);
    ready = 1'b1; step();
    chk("bp y7",     32'(y_a),     32'd7);
    chk("bp valid7", 32'(valid_a), 32'd1);
    chk("bp pend0",  32'(pend_a),  32'h00);
    step();
    chk("bp drain",  32'(valid_a), 32'd0);

    // Mask
    mask = 8'h08; D = 8'h08; step();
    chk("mask pend",  32'(pend_a),  32'h08);
    chk("mask valid", 32'(valid_a), 32'd0);
    D = 8'h00; step();
    chk("mask held pend",  32'(pend_a),  32'h08);
    chk("mask held valid", 32'(valid_a), 32'd0);
    mask = 8'h00; step();
    chk("unmask valid", 32'(valid_a), 32'd1);
    chk("unmask y",     32'(y_a),     32'd3);
    step();

    // Overrun
    ready = 1'b0;
    D = 8'h01; step();
    D = 8'h00; step();
    chk("ovr held y", 32'(y_a), 32'd0);
    D = 8'h10; step();
    chk("ovr first", 32'(ovr_a), 32'd0);
    D = 8'h00; step();
    D = 8'h10; step();
    chk("ovr second", 32'(ovr_a), 32'd1);
    D = 8'h00; step();
    ready = 1'b1; step(); step(); step();
    chk("ovr sticky", 32'(ovr_a), 32'd1);
    chk("ovr drained", 32'(valid_a), 32'd0);

    // Reset mid-operation
    ready = 1'b0;
    D = 8'h01; step();
    D = 8'h00; step();
    D = 8'h0C; step();
    chk("mid pend",  32'(pend_a),  32'h0C);
    chk("mid valid", 32'(valid_a), 32'd1);
    D = 8'hFF;
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst valid",   32'(valid_a), 32'd0);
    chk("rst y",       32'(y_a),     32'd0);
    chk("rst pending", 32'(pend_a),  32'h00);
    chk("rst overrun", 32'(ovr_a),   32'd0);
    ready = 1'b1; step(); step();
    chk("held no pend",  32'(pend_a),  32'h00);
    chk("held no valid", 32'(valid_a), 32'd0);
    D = 8'hFD; step();
    D = 8'hFF; step();
    chk("reraise pend", 32'(pend_a), 32'h02);
    step();
    chk("reraise valid", 32'(valid_a), 32'd1);
    chk("reraise y",     32'(y_a),     32'd1);

    // Level capture
    D = 8'h00; rst = 1'b1; step();
    rst = 1'b0; ready = 1'b0;
    D = 8'h04; step();
    chk("lvl pend",  32'(pend_c),  32'h04);
    chk("lvl valid0", 32'(valid_c), 32'd0);
    step();
    chk("lvl valid", 32'(valid_c), 32'd1);
    chk("lvl y",     32'(y_c),     32'd2);
    chk("lvl repend", 32'(pend_c), 32'h04);
    chk("lvl no ovr", 32'(ovr_c),  32'd0);
    step();
    chk("lvl ovr", 32'(ovr_c), 32'd1);
    D = 8'h00; ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pending_priority_encoder.md
# pending_priority_encoder

Parametrised N-to-log2(N) encoder that captures request events into a pending register and issues them one at a time, highest priority first, through a registered valid/ready output. It generalises the plain 8:3 binary encoder in three ways: any width, selectable priority direction and edge/level capture, and buffered handshake output. It sits between raw event lines and a single consumer of encoded indices, such as an interrupt or event dispatcher.

## Interface
- N, default 8: number of request lines; must be ≥ 2.
- LSB_FIRST, default 0: 0 = highest index wins; 1 = lowest index wins.
- EDGE, default 1: 1 = capture rising edges of D; 0 = capture D levels every cycle.
- W (localparam) = $clog2(N): width of the encoded index.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- D  in  N  request lines.
- mask  in  N  1 = bit is held pending but not issued.
- y  out  W  encoded index of the issued request.
- valid  out  1  y holds an unaccepted index.
- ready  in  1  consumer accepts y when valid && ready at a clock edge.
- pending  out  N  captured, not-yet-issued requests.
- overrun  out  1  sticky flag: an event hit a bit that was already pending.

## Operation
- Reset (rst=1 at edge): pending=0, valid=0, y=0, overrun=0, D_q<=D.
  - Levels held through reset are therefore not seen as edges.
- Capture: rise = D & ~D_q when EDGE=1; rise = D when EDGE=0. D_q<=D every cycle.
- Eligible set: elig = pending & ~mask.
- Selection: sel = index of the highest set bit of elig (LSB_FIRST=0) or the lowest set bit (LSB_FIRST=1). any = |elig.
- Load condition: load = any && (!valid || ready).
  - On load: y<=sel, valid<=1, pending[sel] is cleared (issue).
  - Otherwise, if valid && ready: valid<=0.
  - Otherwise: y and valid hold.
- Pending update: pending <= (pending & ~issue_vec) | rise.
  - Set wins over clear on the same bit in the same cycle; that bit is reissued later.
- Overrun: set when rise[i] && pending[i] && !issue_vec[i] for any i. Cleared only by rst.
- A loaded output is never replaced by a higher-priority request while valid && !ready.
- y holds its last value after valid drops.
- Masked bits stay pending indefinitely and become eligible the cycle mask clears.
- With EDGE=0, a held level re-pends the bit every cycle. Overrun then fires whenever the bit is still pending and not issuing.

## Timing
- Latency: D high before edge k with D_q=0 gives pending[i]=1 after edge k.
  - valid=1, y=i after edge k+1, provided the output slot is free or being accepted.
- Throughput: one index per cycle under continuous ready=1.
  - Back-to-back loads occur on the same edge as acceptance; there are no bubbles.
- Output path is registered: y and valid depend only on flops. Selection logic is combinational from pending and mask.
- Reset has priority over every other event, including a simultaneous accept or capture.

## Test plan
- Single event (N=8, EDGE=1, LSB_FIRST=0, ready=1): after reset, D=8'h20 at edge k. Required: pending=8'h20 after edge k; valid=1, y=5, pending=0 after edge k+1; valid=0 after edge k+2.
- Priority order: D=8'h81 with ready=1.
  - LSB_FIRST=0: y=7 then y=0 on consecutive cycles, then valid=0.
  - LSB_FIRST=1: order 0 then 7.
- Backpressure: ready=0 with y=2 valid; then D=8'h80 arrives. Required: y stays 2 and pending=8'h80 while ready=0. One cycle after ready=1: y=7, valid=1.
- Mask: mask=8'h08, D=8'h08. Required: pending=8'h08, valid stays 0. Clear mask: valid=1, y=3 one edge later.
- Overrun: pulse D[4] twice while ready=0 and a prior index is held. Required: overrun=1 after the second capture edge; it stays 1 until rst.
- Reset mid-operation: valid=1, pending=8'h0C, D=8'hFF held high, assert rst for one edge. Required: valid=0, y=0, pending=0, overrun=0. With EDGE=1 and D held, no events afterwards. Dropping and raising D[1] later yields y=1.
